rv32i_mem_top: RTL

Memory stage of the RV32I pipeline. It sits directly downstream of the execute stage and consumes its registered outputs: ALU result, instruction word, PC and write-back enable. Load and store instructions are turned into a req/ready transaction on the data-memory bus, with byte enables, store-data replication, load lane extraction and sign/zero extension. All other instructions pass through to write-back with one cycle of latency. The upstream pipeline is stalled while a transaction is outstanding.

---
 rtl/rv32i_pkg.sv | 49 ++++
 rtl/rv32i_mem_top_if.sv | 21 ++
 rtl/rv32i_load_align.sv | 34 +++
 rtl/rv32i_mem_top.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rv32i_pkg                                                  |
// | Purpose : Shared constants, state type and lane helpers for the      |
// |           RV32I memory stage.                                        |
// | Contents: OP_LOAD/OP_STORE opcodes, F3_* func3 codes, NOP_IW_DEFAULT,|
// |           mem_state_t, calc_be(), calc_wdata().                      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package rv32i_pkg;

  localparam logic [6:0]  OP_LOAD        = 7'b0000011;
  localparam logic [6:0]  OP_STORE       = 7'b0100011;

  localparam logic [2:0]  F3_B           = 3'b000;
  localparam logic [2:0]  F3_H           = 3'b001;
  localparam logic [2:0]  F3_W           = 3'b010;
  localparam logic [2:0]  F3_BU          = 3'b100;
  localparam logic [2:0]  F3_HU          = 3'b101;

  // ADDI x0,x0,0 - the bubble seen by write-back
  localparam logic [31:0] NOP_IW_DEFAULT = 32'h00000013;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  // size is func3[1:0]: 00 byte, 01 halfword, 10 word (same for loads/stores)
  function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   calc_be = 4'b0001 << a;
      2'b01:   calc_be = a[1] ? 4'b1100 : 4'b0011;
      default: calc_be = 4'b1111;
    endcase
  endfunction

  // Replicating the store data across lanes lets the byte enables alone
  // select the written bytes, so no shifter is needed on the write path.
  function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] rs2);
    case (size)
      2'b00:   calc_wdata = {4{rs2[7:0]}};
      2'b01:   calc_wdata = {2{rs2[15:0]}};
      default: calc_wdata = rs2;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_mem_top_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rv32i_mem_top_if                                           |
// | Purpose : Data-memory req/ready bus of the RV32I memory stage.       |
// | Ports   : req, we, addr[31:0], be[3:0], wdata[31:0]  (master -> mem) |
// |           ready, rdata[31:0]                         (mem -> master) |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface rv32i_mem_top_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input  ready, rdata);
  modport slave  (input  req, we, addr, be, wdata, output ready, rdata);
endinterface
`default_nettype wire

// File: rtl/rv32i_load_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rv32i_load_align                                           |
// | Purpose : Combinational load lane extraction and sign/zero extension.|
// | Ports   : rdata[31:0] in  - raw word from data memory                |
// |           a[1:0]      in  - byte offset of the access                |
// |           func3[2:0]  in  - load width/signedness                    |
// |           data[31:0]  out - value to write back                      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module rv32i_load_align
  import rv32i_pkg::*;
(
  input  wire logic [31:0] rdata,
  input  wire logic [1:0]  a,
  input  wire logic [2:0]  func3,
  output logic      [31:0] data
);

  logic [31:0] w_lane;

  always_comb begin
    w_lane = rdata >> {a, 3'b000};
    case (func3)
      F3_B:    data = {{24{w_lane[7]}},  w_lane[7:0]};
      F3_H:    data = {{16{w_lane[15]}}, w_lane[15:0]};
      F3_BU:   data = {24'd0, w_lane[7:0]};
      F3_HU:   data = {16'd0, w_lane[15:0]};
      default: data = w_lane;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rv32i_mem_top.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rv32i_mem_top                                              |
// | Purpose : RV32I memory stage. Loads/stores become one req/ready      |
// |           transaction on the data bus; all other instructions pass   |
// |           to write-back with one cycle of latency.                   |
// | Ports   : clk, reset                  - clock, sync active-high rst  |
// |           alu_in/iw_in/pc_in/rs2_data_in/wb_en_in - execute stage    |
// |           dmem (master)               - data-memory bus              |
// |           stall                       - hold upstream inputs         |
// |           wb_data_out/iw_out/pc_out/wb_en_out - to write-back        |
// |           misalign_out, bus_err_out   - one-cycle fault pulses       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module rv32i_mem_top
  import rv32i_pkg::*;
#(
  parameter logic [31:0] NOP_IW         = NOP_IW_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic [31:0] alu_in,
  input  wire logic [31:0] iw_in,
  input  wire logic [31:0] pc_in,
  input  wire logic [31:0] rs2_data_in,
  input  wire logic        wb_en_in,
  rv32i_mem_top_if.master  dmem,
  output logic             stall,
  output logic      [31:0] wb_data_out,
  output logic      [31:0] iw_out,
  output logic      [31:0] pc_out,
  output logic             wb_en_out,
  output logic             misalign_out,
  output logic             bus_err_out
);

  localparam int                c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  mem_state_t          r_state, w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt;

  // decode of the execute-stage instruction
  logic [2:0]  w_f3;
  logic        w_is_load, w_is_store, w_mem_op, w_legal, w_misalign;

  // FSM control
  logic        w_issue, w_done, w_abort, w_req;

  // transaction registers, captured when the access is issued
  logic [31:0] r_addr, r_wdata, r_iw, r_pc;
  logic [3:0]  r_be;
  logic [2:0]  r_f3;
  logic        r_we, r_wb_en;

  logic [31:0] w_load_data;

  always_comb begin
    w_f3       = iw_in[14:12];
    w_is_load  = (iw_in[6:0] == OP_LOAD);
    w_is_store = (iw_in[6:0] == OP_STORE);
    w_mem_op   = w_is_load | w_is_store;
    w_legal    = 1'b0;
    if (w_is_load)
      w_legal = (w_f3 == F3_B) || (w_f3 == F3_H) || (w_f3 == F3_W) ||
                (w_f3 == F3_BU) || (w_f3 == F3_HU);
    else if (w_is_store)
      w_legal = (w_f3 == F3_B) || (w_f3 == F3_H) || (w_f3 == F3_W);
    w_misalign = ((w_f3[1:0] == 2'b01) && alu_in[0]) ||
                 ((w_f3[1:0] == 2'b10) && (alu_in[1:0] != 2'b00));
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    stall       = 1'b0;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mem_op && w_legal && !w_misalign) begin
          w_issue     = 1'b1;
          stall       = 1'b1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        w_req = 1'b1;
        if (dmem.ready) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_cnt == c_cnt_last) begin
          // Releasing stall on the abort cycle lets the faulting instruction
          // retire; holding it would make IDLE re-issue the same access.
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign dmem.req   = w_req;
  assign dmem.we    = r_we;
  assign dmem.addr  = {r_addr[31:2], 2'b00};
  assign dmem.be    = r_be;
  assign dmem.wdata = r_wdata;

  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_addr  <= alu_in;
      r_be    <= calc_be(w_f3[1:0], alu_in[1:0]);
      r_wdata <= calc_wdata(w_f3[1:0], rs2_data_in);
      r_we    <= w_is_store;
      r_iw    <= iw_in;
      r_pc    <= pc_in;
      r_f3    <= w_f3;
      r_wb_en <= wb_en_in;
    end
  end

  rv32i_load_align u_load_align (
    .rdata (dmem.rdata),
    .a     (r_addr[1:0]),
    .func3 (r_f3),
    .data  (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_data_out  <= 32'd0;
      iw_out       <= NOP_IW;
      pc_out       <= 32'd0;
      wb_en_out    <= 1'b0;
      misalign_out <= 1'b0;
      bus_err_out  <= 1'b0;
      r_cnt        <= '0;
    end else begin
      misalign_out <= 1'b0;
      bus_err_out  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            iw_out    <= NOP_IW;
            wb_en_out <= 1'b0;
          end else begin
            // plain op, or a memory op dropped for illegal func3/alignment
            wb_data_out  <= alu_in;
            iw_out       <= iw_in;
            pc_out       <= pc_in;
            wb_en_out    <= w_mem_op ? 1'b0 : wb_en_in;
            misalign_out <= w_mem_op & w_legal & w_misalign;
          end
        end
        ACCESS: begin
          if (w_done) begin
            wb_data_out <= r_we ? r_addr : w_load_data;
            wb_en_out   <= r_we ? 1'b0 : r_wb_en;
            iw_out      <= r_iw;
            pc_out      <= r_pc;
            r_cnt       <= '0;
          end else if (w_abort) begin
            bus_err_out <= 1'b1;
            wb_en_out   <= 1'b0;
            iw_out      <= r_iw;
            pc_out      <= r_pc;
            r_cnt       <= '0;
          end else begin
            iw_out      <= NOP_IW;
            wb_en_out   <= 1'b0;
            r_cnt       <= r_cnt + c_cnt_one;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
